// File: rtl/mem_access_unit_if.sv
// Handshake bundle between pipeline, memory and mem_access_unit.
// The unit binds to the slave modport; pipeline and memory drive via master.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signext;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signext,
    output req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr,
    input  mem_be, mem_wdata, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signext,
    input  req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr,
    output mem_be, mem_wdata, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: aligns requests onto a 32-bit memory bus,
// waits for ack with a timeout and returns extended load data.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input logic               clk,
  input logic               reset,
  mem_access_unit_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_ACCESS = 2'b01;
  localparam logic [1:0] S_RESP   = 2'b10;
  localparam logic [7:0] LAST     = 8'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic        r_we;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic        r_sx;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_wdata;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;

  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_lane;
  logic [31:0] w_ext;

  // Decode alignment, lane enables and replicated store data
  always_comb begin
    w_misalign = 1'b0;
    w_be       = 4'b1111;
    w_wdata    = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        w_be    = 4'b0001 << bus.req_addr[1:0];
        w_wdata = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        w_misalign = bus.req_addr[0];
        w_be       = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {2{bus.req_wdata[15:0]}};
      end
      2'b10: w_misalign = |bus.req_addr[1:0];
      default: w_misalign = 1'b1;
    endcase
  end

  // Shift the addressed lane down and extend it to 32 bits
  always_comb begin
    w_lane = bus.mem_rdata >> {r_off, 3'b000};
    case (r_size)
      2'b00: w_ext = {{24{r_sx & w_lane[7]}}, w_lane[7:0]};
      2'b01: w_ext = {{16{r_sx & w_lane[15]}}, w_lane[15:0]};
      default: w_ext = w_lane;
    endcase
  end

  // Control FSM with registered bus outputs and response
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_off        <= 2'b00;
      r_sx         <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_be     <= 4'd0;
      r_mem_wdata  <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= (r_state == S_RESP);
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_we   <= bus.req_we;
            r_size <= bus.req_size;
            r_off  <= bus.req_addr[1:0];
            r_sx   <= bus.req_signext;
            if (w_misalign) begin
              r_state      <= S_RESP;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'd0;
            end else begin
              r_state     <= S_ACCESS;
              r_cnt       <= 8'd0;
              r_mem_req   <= 1'b1;
              r_mem_we    <= bus.req_we;
              r_mem_addr  <= {bus.req_addr[31:2], 2'b00};
              r_mem_be    <= w_be;
              r_mem_wdata <= w_wdata;
            end
          end
        end
        S_ACCESS: begin
          if (bus.mem_ack) begin
            r_state      <= S_RESP;
            r_mem_req    <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= r_we ? 32'd0 : w_ext;
          end else if (r_cnt == LAST) begin
            r_state      <= S_RESP;
            r_mem_req    <= 1'b0;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_be     = r_mem_be;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;

endmodule
